card_shuffle_gen: RTL and testbench

//  Builds a shuffled deck for a new game: fills a local buffer with colour pairs (0,0,1,1,..),

---
 rtl/card_shuffle_gen_if.sv | 36 +++
 rtl/card_shuffle_gen.sv | 192 +++++++++++++++++++
 tb/tb_card_shuffle_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/card_shuffle_gen_if.sv
// Request/stream bundle for card_shuffle_gen.
// The seed field exists only when CARD_SHUFFLE_SEED_EN is defined.
interface card_shuffle_gen_if #(
    parameter int ADDR_W  = 4,
    parameter int COLOR_W = 3,
    parameter int STATE_W = 2
);
    logic                       enable;
    logic [ADDR_W:0]            num_of_cards;
`ifdef CARD_SHUFFLE_SEED_EN
    logic [15:0]                seed;
`endif
    logic                       busy;
    logic                       computed_valid;
    logic [ADDR_W-1:0]          computed_address;
    logic [COLOR_W+STATE_W-1:0] computed_data;
    logic                       done;

    // Requester side: starts a deck build and receives the card stream.
    modport master (
`ifdef CARD_SHUFFLE_SEED_EN
        output seed,
`endif
        output enable, num_of_cards,
        input  busy, computed_valid, computed_address, computed_data, done
    );

    // Generator side.
    modport slave (
`ifdef CARD_SHUFFLE_SEED_EN
        input  seed,
`endif
        input  enable, num_of_cards,
        output busy, computed_valid, computed_address, computed_data, done
    );
endinterface

// File: rtl/card_shuffle_gen.sv
// card_shuffle_gen: builds a shuffled deck of colour pairs and streams it out.
// Fill buffer with 0,0,1,1,..; Fisher-Yates shuffle driven by a 16-bit LFSR;
// then one {colour, HIDDEN} word per cycle.
// Optional feature macro: CARD_SHUFFLE_SEED_EN (adds a seed load on start).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for enable; LFSR free-runs
// S_FILL    | writing buf[k] = k>>1 for k = 0..n-1
// S_SHUFFLE | i = n-1 down to 1; draw j, retry while j > i, else swap
// S_OUT     | strobing buf[0..n-1] out, one card per cycle
// S_FINISH  | last state before the done pulse
module card_shuffle_gen #(
    parameter int MAX_CARDS = 16,
    parameter int ADDR_W    = 4,
    parameter int COLOR_W   = 3,
    parameter int STATE_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    card_shuffle_gen_if.slave  bus
);
    localparam int              N_W        = ADDR_W + 1;
    localparam logic [N_W-1:0]  N_MAX      = N_W'(MAX_CARDS);
    localparam logic [15:0]     LFSR_INIT  = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SHUFFLE,
        S_OUT,
        S_FINISH
    } state_t;

    state_t                      state_q, state_d;
    logic [15:0]                 lfsr_q, lfsr_d;
    logic [N_W-1:0]              n_q, n_d;
    logic [ADDR_W-1:0]           cnt_q, cnt_d;
    logic                        busy_q, busy_d;
    logic                        valid_q, valid_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [COLOR_W+STATE_W-1:0]  data_q, data_d;
    logic                        done_q, done_d;

    logic [COLOR_W-1:0]          buf_q [MAX_CARDS];

    logic [15:0]                 lfsr_step;
    logic [N_W-1:0]              n_req;
    logic [N_W-1:0]              n_clamp;
    logic [N_W-1:0]              n_last;
    logic                        cnt_last;
    logic                        start;
    logic [ADDR_W-1:0]           j_idx;
    logic                        swap_ok;
    logic                        fill_we;
    logic                        swap_we;

    // Smallest all-ones value covering v: smear the top set bit downwards.
    function automatic logic [ADDR_W-1:0] cover_mask(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] m;
        m = v;
        for (int s = 1; s < ADDR_W; s++) begin
            m = m | (v >> s);
        end
        return m;
    endfunction

    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Odd requests drop to the next even size; oversize requests fill the buffer.
    assign n_req    = bus.num_of_cards & ~N_W'(1);
    assign n_clamp  = (n_req > N_MAX) ? N_MAX : n_req;
    assign n_last   = n_q - N_W'(1);
    assign cnt_last = ({1'b0, cnt_q} == n_last);

    // The done cycle still reports busy, so a request landing on it is ignored
    // even though the state register is already back in IDLE.
    assign start    = (state_q == S_IDLE) && bus.enable && !done_q;

    // In SHUFFLE cnt_q is the Fisher-Yates index i.
    assign j_idx    = lfsr_q[ADDR_W-1:0] & cover_mask(cnt_q);
    assign swap_ok  = (j_idx <= cnt_q);

    // State, LFSR and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_INIT;
            n_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter and buffer-strobe logic.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_step;
        fill_we = 1'b0;
        swap_we = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_clamp;
                    cnt_d   = '0;
                    state_d = (n_clamp < N_W'(2)) ? S_FINISH : S_FILL;
`ifdef CARD_SHUFFLE_SEED_EN
                    lfsr_d  = (bus.seed == 16'h0000) ? LFSR_INIT : bus.seed;
`endif
                end
            end
            S_FILL: begin
                fill_we = 1'b1;
                if (cnt_last) begin
                    cnt_d   = ADDR_W'(n_last);
                    state_d = S_SHUFFLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_SHUFFLE: begin
                if (swap_ok) begin
                    swap_we = 1'b1;
                    if (cnt_q == ADDR_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_OUT;
                    end else begin
                        cnt_d = cnt_q - ADDR_W'(1);
                    end
                end
            end
            S_OUT: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output words lag the state by one cycle so every output is a flop.
    always_comb begin
        valid_d = (state_q == S_OUT);
        addr_d  = valid_d ? cnt_q : '0;
        data_d  = valid_d ? {buf_q[cnt_q], {STATE_W{1'b0}}} : '0;
        done_d  = (state_q == S_FINISH);
        busy_d  = (state_d != S_IDLE) || (state_q == S_FINISH);
    end

    // Deck storage: fill writes and shuffle swaps; contents need no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            buf_q[cnt_q] <= COLOR_W'(cnt_q >> 1);
        end
        if (swap_we) begin
            buf_q[cnt_q] <= buf_q[j_idx];
            buf_q[j_idx] <= buf_q[cnt_q];
        end
    end

    assign bus.busy             = busy_q;
    assign bus.computed_valid   = valid_q;
    assign bus.computed_address = addr_q;
    assign bus.computed_data    = data_q;
    assign bus.done             = done_q;

endmodule

// File: tb/tb_card_shuffle_gen.sv
// Bench for card_shuffle_gen: reference Fisher-Yates model fills a scoreboard
// at each start; a negedge monitor pops and compares every strobe.
module tb_card_shuffle_gen;
    localparam int MAX_CARDS = 16;
    localparam int ADDR_W    = 4;
    localparam int COLOR_W   = 3;
    localparam int STATE_W   = 2;
    localparam int DATA_W    = COLOR_W + STATE_W;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    card_shuffle_gen_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .STATE_W(STATE_W)) bus ();

    card_shuffle_gen #(
        .MAX_CARDS (MAX_CARDS),
        .ADDR_W    (ADDR_W),
        .COLOR_W   (COLOR_W),
        .STATE_W   (STATE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR follows the DUT clock; records its value at each start.
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_at_start;
    int          start_cnt = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_m <= 16'hACE1;
        end else if (bus.enable && !bus.busy) begin
`ifdef CARD_SHUFFLE_SEED_EN
            lfsr_m        <= (bus.seed == 16'h0) ? 16'hACE1 : bus.seed;
            lfsr_at_start <= (bus.seed == 16'h0) ? 16'hACE1 : bus.seed;
`else
            lfsr_m        <= lfsr_next(lfsr_m);
            lfsr_at_start <= lfsr_next(lfsr_m);
`endif
            start_cnt <= start_cnt + 1;
        end else begin
            lfsr_m <= lfsr_next(lfsr_m);
        end
    end

    exp_t        sb_q[$];
    int          cyc = 0;
    int          strobes = 0;
    int          dones = 0;
    int          last_strobe_cyc = -1;
    int          done_cyc = -1;
    int          hist[1 << COLOR_W];
    logic [63:0] seq_acc;

    // Monitor: every strobe is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst && bus.computed_valid) begin
            strobes++;
            last_strobe_cyc = cyc;
            hist[int'(bus.computed_data[DATA_W-1:STATE_W])]++;
            seq_acc = {seq_acc[60:0], bus.computed_data[DATA_W-1:STATE_W]};
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
            check_val("addr", int'(bus.computed_address), int'(e.a));
            check_val("data", int'(bus.computed_data), int'(e.d));
        end
        if (rst && bus.done) begin
            dones++;
            done_cyc = cyc;
        end
    end

    // Fisher-Yates reference: one LFSR step per FILL cycle and per draw.
    task automatic predict(input int n);
        logic [15:0]        l;
        logic [COLOR_W-1:0] deck[MAX_CARDS];
        logic [COLOR_W-1:0] t;
        int                 i, j, mask;
        exp_t               e;
        l = lfsr_at_start;
        for (int k = 0; k < n; k++) begin
            deck[k] = COLOR_W'(k / 2);
            l = lfsr_next(l);
        end
        i = n - 1;
        while (i >= 1) begin
            mask = 1;
            while (mask < i) mask = mask * 2 + 1;
            j = int'(l[ADDR_W-1:0]) & mask;
            l = lfsr_next(l);
            if (j <= i) begin
                t       = deck[i];
                deck[i] = deck[j];
                deck[j] = t;
                i--;
            end
        end
        for (int k = 0; k < n; k++) begin
            e.a = ADDR_W'(k);
            e.d = {deck[k], {STATE_W{1'b0}}};
            sb_q.push_back(e);
        end
    endtask

    task automatic run(input int num, input logic [15:0] sd, input bit poke);
        int n, s0, d0, st0, t_en;
        n = num & ~1;
        if (n > MAX_CARDS) n = MAX_CARDS;
        s0  = strobes;
        d0  = dones;
        st0 = start_cnt;
        for (int c = 0; c < (1 << COLOR_W); c++) hist[c] = 0;
        seq_acc = '0;
        @(negedge clk);
        bus.num_of_cards = (ADDR_W + 1)'(num);
`ifdef CARD_SHUFFLE_SEED_EN
        bus.seed = sd;
`endif
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        t_en = cyc;
        check_val("start_seen", start_cnt - st0, 1);
        check_val("busy_rise", int'(bus.busy), 1);
        if (n >= 2) predict(n);
        for (int k = 0; k < 1000 && dones == d0; k++) begin
            @(negedge clk);
            #1;
            bus.enable       = poke && (k % 5 == 2);
            bus.num_of_cards = poke ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(num);
        end
        bus.enable = 1'b0;
        check_val("done_cnt", dones - d0, 1);
        check_val("busy_at_done", int'(bus.busy), 1);
        check_val("strobe_cnt", strobes - s0, n);
        if (n >= 2) check_val("done_after_last", done_cyc - last_strobe_cyc, 1);
        else        check_val("done_latency", done_cyc - t_en, 2);
        @(negedge clk);
        #1;
        check_val("busy_fall", int'(bus.busy), 0);
        check_val("done_pulse_len", int'(bus.done), 0);
        repeat (40) @(negedge clk);
        #1;
        check_val("extra_done", dones - d0, 1);
        check_val("extra_strobes", strobes - s0, n);
        check_val("sb_left", sb_q.size(), 0);
        for (int c = 0; c < n / 2; c++) check_val("pair_cnt", hist[c], 2);
        sb_q.delete();
        if (sd == 16'hFFFF) check_val("unused", 0, 0);
    endtask

    initial begin
        logic [63:0] seq_a;
        int          seen;
        bus.enable       = 1'b0;
        bus.num_of_cards = '0;
`ifdef CARD_SHUFFLE_SEED_EN
        bus.seed         = 16'h0;
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_valid", int'(bus.computed_valid), 0);
        check_val("rst_busy",  int'(bus.busy), 0);
        check_val("rst_done",  int'(bus.done), 0);
        check_val("rst_addr",  int'(bus.computed_address), 0);
        check_val("rst_data",  int'(bus.computed_data), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        run(16, 16'h1234, 1'b0);
        seq_a = seq_acc;
`ifdef CARD_SHUFFLE_SEED_EN
        run(16, 16'h1234, 1'b0);
        check_val("same_seed_same_deck", int'(seq_acc == seq_a), 1);
        run(16, 16'h4321, 1'b0);
        check_val("other_seed_differs", int'(seq_acc != seq_a), 1);
        run(16, 16'h0000, 1'b0);
`endif
        run(5,  16'h0042, 1'b0);
        run(31, 16'h0777, 1'b0);
        run(2,  16'h0101, 1'b0);
        run(0,  16'h0203, 1'b0);
        run(1,  16'h0305, 1'b0);
        run(16, 16'h5A5A, 1'b1);

        // Abort on the third OUT strobe, then check a clean rerun.
        @(negedge clk);
        bus.num_of_cards = (ADDR_W + 1)'(16);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        predict(16);
        seen = 0;
        for (int k = 0; k < 1000 && seen < 3; k++) begin
            @(negedge clk);
            #1;
            if (bus.computed_valid) seen++;
        end
        check_val("abort_strobe_seen", seen, 3);
        rst = 1'b0;
        #1;
        check_val("abort_valid", int'(bus.computed_valid), 0);
        check_val("abort_busy",  int'(bus.busy), 0);
        check_val("abort_done",  int'(bus.done), 0);
        sb_q.delete();
        seen = strobes;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("abort_no_more", strobes - seen, 0);
        run(16, 16'h1234, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
